// File: rtl/inertial_integrator_p.sv
// inertial_integrator_p: gyro offset calibration, saturating rate integration
// and complementary accel leak for pitch/roll.
// Optional build macro: RATE_DEADBAND_EN zeroes small compensated rates in RUN.
//
// state | meaning
// IDLE  | waiting for strt_cal, only the accel averager runs
// CAL   | summing 2^SMPL_CNT_WIDTH raw samples per axis to derive offsets
// RUN   | integrating offset-compensated rates plus accel fusion leak
module inertial_integrator_p #(
  parameter int DATA_W         = 16,
  parameter int SMPL_CNT_WIDTH = 11,
  parameter int INT_W          = 27,
  parameter int INT_SHIFT      = 13,
  parameter int AVG_LOG2       = 4,
  parameter int FUSION_K       = 327,
  parameter int G_SHIFT        = 13,
  parameter int LEAK_UP        = 2048,
  parameter int LEAK_DN        = 4096,
  parameter int DEADBAND       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt_cal,
  input  logic                     vld,
  input  logic signed [DATA_W-1:0] ptch_rt,
  input  logic signed [DATA_W-1:0] roll_rt,
  input  logic signed [DATA_W-1:0] yaw_rt,
  input  logic signed [DATA_W-1:0] ax,
  input  logic signed [DATA_W-1:0] ay,
  output logic                     cal_done,
  output logic                     running,
  output logic                     ovf,
  output logic signed [DATA_W-1:0] ptch,
  output logic signed [DATA_W-1:0] roll,
  output logic signed [DATA_W-1:0] yaw
);

  localparam int AW = DATA_W + AVG_LOG2;
  localparam int PW = DATA_W + 33;
  localparam int SW = INT_W + 2;

`ifdef RATE_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif

  localparam logic signed [DATA_W:0]   DB_P    = (DATA_W+1)'(DEADBAND);
  localparam logic signed [DATA_W:0]   DB_N    = -DB_P;
  localparam logic signed [PW-1:0]     K_W     = PW'(FUSION_K);
  localparam logic signed [SW-1:0]     LEAK_P  = SW'(LEAK_UP);
  localparam logic signed [SW-1:0]     LEAK_N  = -(SW'(LEAK_DN));
  localparam logic signed [SW-1:0]     SAT_MAX = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     SAT_MIN = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic signed [INT_W-1:0]  INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0]  INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [INT_W-1:0]  OUT_MAX = {{(INT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0]  OUT_MIN = {{(INT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

  state_t                     state;
  logic [SMPL_CNT_WIDTH-1:0]  smpl_cnt;
  logic signed [INT_W-1:0]    intg    [3];
  logic signed [DATA_W-1:0]   off     [3];
  logic signed [DATA_W-1:0]   rate    [3];
  logic signed [DATA_W-1:0]   ang     [3];
  logic signed [INT_W-1:0]    shf     [3];
  logic signed [DATA_W:0]     comp    [3];
  logic signed [DATA_W:0]     comp_db [3];
  logic signed [SW-1:0]       fus_raw [3];
  logic signed [SW-1:0]       addend  [3];
  logic signed [SW-1:0]       fus     [3];
  logic signed [SW-1:0]       sum     [3];
  logic signed [INT_W-1:0]    nxt     [3];
  logic [2:0]                 hit;

  logic [AVG_LOG2-1:0]        avg_cnt;
  logic signed [AW-1:0]       ax_acc, ay_acc, ax_sum, ay_sum;
  logic signed [DATA_W-1:0]   ax_avg, ay_avg;
  logic signed [DATA_W:0]     ay_x, ax_neg;
  logic signed [PW-1:0]       ptch_g, roll_g;

  assign rate[0] = ptch_rt;
  assign rate[1] = roll_rt;
  assign rate[2] = yaw_rt;
  assign ptch    = ang[0];
  assign roll    = ang[1];
  assign yaw     = ang[2];

  // Accel angles; roll negation is done one bit wider so the most-negative average is exact.
  assign ay_x    = {ay_avg[DATA_W-1], ay_avg};
  assign ax_neg  = -{ax_avg[DATA_W-1], ax_avg};
  assign ptch_g  = (PW'(ay_x) * K_W) >>> G_SHIFT;
  assign roll_g  = (PW'(ax_neg) * K_W) >>> G_SHIFT;

  assign fus_raw[0] = (ptch_g > PW'(ang[0])) ? LEAK_P : LEAK_N;
  assign fus_raw[1] = (roll_g > PW'(ang[1])) ? LEAK_P : LEAK_N;
  assign fus_raw[2] = '0;

  assign ax_sum = ax_acc + AW'(ax);
  assign ay_sum = ay_acc + AW'(ay);

  // Output angles: scaled integrators clamped into the DATA_W signed range.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shf[i] = intg[i] >>> INT_SHIFT;
      if (shf[i] > OUT_MAX)      ang[i] = DATA_W'(OUT_MAX);
      else if (shf[i] < OUT_MIN) ang[i] = DATA_W'(OUT_MIN);
      else                       ang[i] = DATA_W'(shf[i]);
    end
  end

  // Next integrator values: raw rate in CAL, compensated rate plus fusion in RUN, saturated.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      comp[i]    = {rate[i][DATA_W-1], rate[i]} - {off[i][DATA_W-1], off[i]};
      comp_db[i] = (DB_EN && comp[i] <= DB_P && comp[i] >= DB_N) ? '0 : comp[i];
      addend[i]  = '0;
      fus[i]     = '0;
      if (state == CAL) begin
        addend[i] = SW'(rate[i]);
      end else if (state == RUN) begin
        addend[i] = SW'(comp_db[i]);
        fus[i]    = fus_raw[i];
      end
      sum[i] = SW'(intg[i]) + addend[i] + fus[i];
      if (sum[i] > SAT_MAX) begin
        nxt[i] = INT_MAX;
        hit[i] = 1'b1;
      end else if (sum[i] < SAT_MIN) begin
        nxt[i] = INT_MIN;
        hit[i] = 1'b1;
      end else begin
        nxt[i] = INT_W'(sum[i]);
      end
    end
  end

  // Accel block averager: every 2^AVG_LOG2 vld strobes, regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_cnt <= '0;
      ax_acc  <= '0;
      ay_acc  <= '0;
      ax_avg  <= '0;
      ay_avg  <= '0;
    end else if (vld) begin
      avg_cnt <= avg_cnt + 1'b1;
      if (&avg_cnt) begin
        ax_avg <= DATA_W'(ax_sum >>> AVG_LOG2);
        ay_avg <= DATA_W'(ay_sum >>> AVG_LOG2);
        ax_acc <= '0;
        ay_acc <= '0;
      end else begin
        ax_acc <= ax_sum;
        ay_acc <= ay_sum;
      end
    end
  end

  // Sequencing FSM with registered status outputs, integrators and offsets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cal_done <= 1'b0;
      running  <= 1'b0;
      ovf      <= 1'b0;
      smpl_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        intg[i] <= '0;
        off[i]  <= '0;
      end
    end else begin
      cal_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt_cal) begin
            state    <= CAL;
            smpl_cnt <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < 3; i++) intg[i] <= '0;
          end
        end
        CAL: begin
          if (strt_cal) begin
            smpl_cnt <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < 3; i++) intg[i] <= '0;
          end else if (vld) begin
            smpl_cnt <= smpl_cnt + 1'b1;
            if (&smpl_cnt) begin
              // The completing sample itself is not folded into the offset.
              state    <= RUN;
              running  <= 1'b1;
              cal_done <= 1'b1;
              for (int i = 0; i < 3; i++) begin
                off[i]  <= DATA_W'(intg[i] >>> SMPL_CNT_WIDTH);
                intg[i] <= '0;
              end
            end else begin
              for (int i = 0; i < 3; i++) intg[i] <= nxt[i];
              if (|hit) ovf <= 1'b1;
            end
          end
        end
        RUN: begin
          if (strt_cal) begin
            state    <= CAL;
            running  <= 1'b0;
            smpl_cnt <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < 3; i++) intg[i] <= '0;
          end else if (vld) begin
            for (int i = 0; i < 3; i++) intg[i] <= nxt[i];
            if (|hit) ovf <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
